// File: rtl/uart_pkg.sv
// UART shared types and helpers.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  localparam int unsigned WORD_MAX = 32;

  function automatic int unsigned baud_div(
    input int unsigned clk_rate,
    input int unsigned baud
  );
    return clk_rate / baud;
  endfunction

  // Expected parity bit; callers zero-extend data.
  function automatic logic parity_calc(
    input logic [WORD_MAX-1:0] data,
    input parity_e             mode
  );
    logic p;
    logic r;
    p = ^data;
    unique case (mode)
      PAR_EVEN: r = p;
      PAR_ODD:  r = ~p;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin.
// Resets to the idle (high) line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, data (LSB first), optional parity, stop.
// Single-entry output buffer on a valid/ready stream.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_rate = 50_000_000,
  parameter int unsigned Baud     = 115200,
  parameter int unsigned Word_len = 8,
  parameter string       PARITY   = "even"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Uart_rx,
  output logic [Word_len-1:0] rx_data,
  output logic                rx_data_valid,
  input  logic                rx_data_ready,
  output logic                rx_parity_err,
  output logic                rx_frame_err,
  output logic                rx_overrun
);

  localparam int unsigned BDIV = baud_div(clk_rate, Baud);
  localparam int unsigned H    = BDIV / 2;
  localparam int unsigned CW   = $clog2(BDIV);
  localparam int unsigned BW   = $clog2(Word_len + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BDIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(Word_len - 1);

  localparam parity_e PMODE =
    (PARITY == "none") ? PAR_NONE :
    (PARITY == "odd")  ? PAR_ODD  : PAR_EVEN;

  logic                rx_s;
  uart_state_e         state_q;
  logic [CW-1:0]       baud_cnt_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [Word_len-1:0] shift_q;
  logic                par_bad_q;
  logic [Word_len-1:0] data_q;
  logic                perr_q;
  logic                ferr_q;
  logic                valid_q;
  logic                ovr_q;

  logic                baud_end_d;
  logic                half_end_d;
  logic                last_bit_d;
  logic                par_err_d;
  logic                done_d;
  logic                load_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (Uart_rx),
    .q_o (rx_s)
  );

  assign baud_end_d = (baud_cnt_q == BAUD_LAST);
  assign half_end_d = (baud_cnt_q == HALF_LAST);
  assign last_bit_d = (bit_cnt_q == BIT_LAST);
  assign par_err_d  = rx_s ^
    parity_calc(WORD_MAX'(shift_q), PMODE);
  assign done_d     = (state_q == ST_STOP) && baud_end_d;
  assign load_d     = done_d && (!valid_q || rx_data_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          par_bad_q  <= 1'b0;
          if (!rx_s) state_q <= ST_START;
        end
        ST_START: begin
          if (half_end_d) begin
            baud_cnt_q <= '0;
            state_q    <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end_d) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s, shift_q[Word_len-1:1]};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (last_bit_d) begin
              state_q <= (PMODE == PAR_NONE) ?
                ST_STOP : ST_PARITY;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (baud_end_d) begin
            baud_cnt_q <= '0;
            par_bad_q  <= par_err_d;
            state_q    <= ST_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Leave mid stop bit so the next start edge is not missed.
          if (baud_end_d) begin
            baud_cnt_q <= '0;
            state_q    <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (done_d) begin
        if (load_d) begin
          data_q  <= shift_q;
          perr_q  <= par_bad_q;
          ferr_q  <= !rx_s;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: even, odd and no-parity
// instances share one serial line and one ready input.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic rdy = 1'b1;

  logic [7:0] d  [3];
  logic       v  [3];
  logic       pe [3];
  logic       fe [3];
  logic       ov [3];

  int cyc = 0;
  int errs = 0;
  int checks = 0;

  int ncnt     [3] = '{0, 0, 0};
  int vhigh    [3] = '{0, 0, 0};
  int novr     [3] = '{0, 0, 0};
  int rise_cyc [3] = '{0, 0, 0};
  int ovr_cyc  [3] = '{0, 0, 0};
  logic vprev  [3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] log_q [3][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.clk_rate(1600), .Baud(100), .Word_len(8),
            .PARITY("even")) u_even (
    .clk(clk), .rst(rst), .Uart_rx(line),
    .rx_data(d[0]), .rx_data_valid(v[0]),
    .rx_data_ready(rdy), .rx_parity_err(pe[0]),
    .rx_frame_err(fe[0]), .rx_overrun(ov[0]));

  uart_rx #(.clk_rate(1600), .Baud(100), .Word_len(8),
            .PARITY("odd")) u_odd (
    .clk(clk), .rst(rst), .Uart_rx(line),
    .rx_data(d[1]), .rx_data_valid(v[1]),
    .rx_data_ready(rdy), .rx_parity_err(pe[1]),
    .rx_frame_err(fe[1]), .rx_overrun(ov[1]));

  uart_rx #(.clk_rate(1600), .Baud(100), .Word_len(8),
            .PARITY("none")) u_none (
    .clk(clk), .rst(rst), .Uart_rx(line),
    .rx_data(d[2]), .rx_data_valid(v[2]),
    .rx_data_ready(rdy), .rx_parity_err(pe[2]),
    .rx_frame_err(fe[2]), .rx_overrun(ov[2]));

  // Transfer log, sampled mid low phase.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (v[i] && rdy && !rst) begin
        if (ncnt[i] < 64)
          log_q[i][ncnt[i]] = {fe[i], pe[i], d[i]};
        ncnt[i] = ncnt[i] + 1;
      end
      if (v[i]) vhigh[i] = vhigh[i] + 1;
      if (v[i] && !vprev[i]) rise_cyc[i] = cyc;
      if (ov[i]) begin
        novr[i] = novr[i] + 1;
        ovr_cyc[i] = cyc;
      end
      vprev[i] = v[i];
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data,
                            input logic use_par,
                            input logic par,
                            input logic stop,
                            output int c0);
    c0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (use_par) send_bit(par);
    send_bit(stop);
    line = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_reset();
    checks++;
    if (v[0] !== 1'b0) begin
      errs++; $display("FAIL rst_valid got=%0h exp=0", v[0]);
    end
    checks++;
    if (d[0] !== 8'h00) begin
      errs++; $display("FAIL rst_data got=%0h exp=0", d[0]);
    end
    checks++;
    if ({pe[0], fe[0]} !== 2'b00) begin
      errs++; $display("FAIL rst_flags got=%0h exp=0", {pe[0], fe[0]});
    end
    checks++;
    if (ov[0] !== 1'b0) begin
      errs++; $display("FAIL rst_ovr got=%0h exp=0", ov[0]);
    end
    checks++;
    if (u_even.state_q !== ST_IDLE) begin
      errs++; $display("FAIL rst_state got=%0d exp=%0d",
                       u_even.state_q, ST_IDLE);
    end
  endtask

  task automatic test_basic_even();
    int c0, b0, b1, vh;
    logic [9:0] e;
    b0 = ncnt[0]; b1 = ncnt[1]; vh = vhigh[0];
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, c0);
    idle(10);
    checks++;
    if (ncnt[0] - b0 !== 1) begin
      errs++; $display("FAIL basic_count got=%0d exp=1", ncnt[0] - b0);
    end
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h0A5) begin
      errs++; $display("FAIL basic_word got=%0h exp=0a5", e);
    end
    checks++;
    if (rise_cyc[0] !== c0 + 171) begin
      errs++; $display("FAIL basic_latency got=%0d exp=%0d",
                       rise_cyc[0], c0 + 171);
    end
    checks++;
    if (vhigh[0] - vh !== 1) begin
      errs++; $display("FAIL basic_valid_len got=%0d exp=1",
                       vhigh[0] - vh);
    end
    e = log_q[1][b1];
    checks++;
    if (e !== 10'h1A5) begin
      errs++; $display("FAIL odd_sees_err got=%0h exp=1a5", e);
    end
  endtask

  task automatic test_parity();
    int c0, b0, b1;
    logic [9:0] e;
    b0 = ncnt[0];
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, c0);
    idle(10);
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h1A5) begin
      errs++; $display("FAIL even_perr got=%0h exp=1a5", e);
    end
    b0 = ncnt[0]; b1 = ncnt[1];
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, c0);
    idle(10);
    checks++;
    if (ncnt[1] - b1 !== 1) begin
      errs++; $display("FAIL odd_count got=%0d exp=1", ncnt[1] - b1);
    end
    e = log_q[1][b1];
    checks++;
    if (e !== 10'h000) begin
      errs++; $display("FAIL odd_ok got=%0h exp=000", e);
    end
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h100) begin
      errs++; $display("FAIL even_zero_perr got=%0h exp=100", e);
    end
  endtask

  task automatic test_break();
    int c0, b0;
    logic [9:0] e;
    b0 = ncnt[0];
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, c0);
    line = 1'b0;
    idle(40);
    line = 1'b1;
    idle(30);
    checks++;
    if (ncnt[0] - b0 !== 1) begin
      errs++; $display("FAIL break_count got=%0d exp=1", ncnt[0] - b0);
    end
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h281) begin
      errs++; $display("FAIL break_ferr got=%0h exp=281", e);
    end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, c0);
    idle(10);
    checks++;
    if (ncnt[0] - b0 !== 2) begin
      errs++; $display("FAIL break_next_count got=%0d exp=2",
                       ncnt[0] - b0);
    end
    e = log_q[0][b0 + 1];
    checks++;
    if (e !== 10'h03C) begin
      errs++; $display("FAIL break_next got=%0h exp=03c", e);
    end
  endtask

  task automatic test_glitch();
    int c0, b0, vh;
    logic [9:0] e;
    b0 = ncnt[0]; vh = vhigh[0];
    line = 1'b0;
    idle(5);
    line = 1'b1;
    idle(30);
    checks++;
    if (vhigh[0] - vh !== 0) begin
      errs++; $display("FAIL glitch_valid got=%0d exp=0", vhigh[0] - vh);
    end
    checks++;
    if (u_even.state_q !== ST_IDLE) begin
      errs++; $display("FAIL glitch_state got=%0d exp=%0d",
                       u_even.state_q, ST_IDLE);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, c0);
    idle(10);
    checks++;
    if (ncnt[0] - b0 !== 1) begin
      errs++; $display("FAIL glitch_count got=%0d exp=1", ncnt[0] - b0);
    end
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h05A) begin
      errs++; $display("FAIL glitch_next got=%0h exp=05a", e);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, b0, no;
    logic [9:0] e;
    rdy = 1'b0;
    b0 = ncnt[0]; no = novr[0];
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, c0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, c1);
    idle(10);
    checks++;
    if (novr[0] - no !== 1) begin
      errs++; $display("FAIL ovr_len got=%0d exp=1", novr[0] - no);
    end
    checks++;
    if (ovr_cyc[0] !== c1 + 171) begin
      errs++; $display("FAIL ovr_time got=%0d exp=%0d",
                       ovr_cyc[0], c1 + 171);
    end
    checks++;
    if ({v[0], d[0]} !== 9'h111) begin
      errs++; $display("FAIL ovr_hold got=%0h exp=111", {v[0], d[0]});
    end
    rdy = 1'b1;
    idle(5);
    checks++;
    if (ncnt[0] - b0 !== 1) begin
      errs++; $display("FAIL ovr_xfer got=%0d exp=1", ncnt[0] - b0);
    end
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h011) begin
      errs++; $display("FAIL ovr_word got=%0h exp=011", e);
    end
    checks++;
    if (v[0] !== 1'b0) begin
      errs++; $display("FAIL ovr_drop got=%0h exp=0", v[0]);
    end
  endtask

  task automatic test_mid_reset();
    int c0, b0, vh;
    logic [9:0] e;
    logic [7:0] pat;
    pat = 8'h77;
    b0 = ncnt[0]; vh = vhigh[0];
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(pat[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    line = 1'b1;
    checks++;
    if (v[0] !== 1'b0) begin
      errs++; $display("FAIL mrst_valid got=%0h exp=0", v[0]);
    end
    idle(250);
    checks++;
    if (vhigh[0] - vh !== 0) begin
      errs++; $display("FAIL mrst_no_word got=%0d exp=0", vhigh[0] - vh);
    end
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, c0);
    idle(10);
    checks++;
    if (ncnt[0] - b0 !== 1) begin
      errs++; $display("FAIL mrst_count got=%0d exp=1", ncnt[0] - b0);
    end
    e = log_q[0][b0];
    checks++;
    if (e !== 10'h0C3) begin
      errs++; $display("FAIL mrst_word got=%0h exp=0c3", e);
    end
  endtask

  task automatic test_no_parity();
    int c0, b2;
    logic [9:0] e;
    pulse_reset();
    b2 = ncnt[2];
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, c0);
    idle(10);
    checks++;
    if (ncnt[2] - b2 !== 1) begin
      errs++; $display("FAIL none_count got=%0d exp=1", ncnt[2] - b2);
    end
    e = log_q[2][b2];
    checks++;
    if (e !== 10'h0FF) begin
      errs++; $display("FAIL none_word got=%0h exp=0ff", e);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    test_reset();
    test_basic_even();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    test_no_parity();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver that deserialises 1 start bit, Word_len data bits (LSB first), an optional parity bit and 1 stop bit.
- Presents each received word on a valid/ready stream interface with per-word error flags.
- Counterpart of uart_tx. Sits between the external RX pin and the AXIS-side consumer (FIFO or loopback).

Parameters:
- clk_rate, 50_000_000, system clock frequency in Hz.
- Baud, 115200, line rate in bit/s. Baud_div = clk_rate/Baud (integer division), H = Baud_div/2.
- Word_len, 8, data bits per frame.
- PARITY, "even", one of "none", "even", "odd". Same convention as uart_tx: even means the parity bit equals ^data.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- Uart_rx  input  1  serial line; asynchronous; idle high.
- rx_data  output  Word_len  received word; stable while rx_data_valid=1.
- rx_data_valid  output  1  word available.
- rx_data_ready  input  1  consumer accepts; a transfer occurs when valid&ready.
- rx_parity_err  output  1  qualified by valid; received parity bit ≠ expected. Always 0 when PARITY="none".
- rx_frame_err  output  1  qualified by valid; stop bit sampled 0.
- rx_overrun  output  1  one-cycle pulse; a completed word was dropped.

Behaviour:
- Reset (rst=1 at a clk edge): state=Idle, counters=0, rx_data=0, rx_data_valid=0, both error flags=0, rx_overrun=0, synchroniser flops=1. Reset mid-frame abandons the frame; nothing is output.
- Uart_rx passes through a 2-flop synchroniser (reset to 1), giving rx_s. All decisions use rx_s only.
- States: Idle, Start, Data, Parity, Stop, Break.
- Idle: baud_cnt=0, bit_cnt=0. If rx_s==0, go to Start.
- Start: baud_cnt counts 0..H-1. At H-1 (mid start bit), sample rx_s:
  - rx_s==1: glitch; return to Idle, no output.
  - rx_s==0: go to Data with baud_cnt=0.
- Data: at baud_cnt==Baud_div-1, sample rx_s into shift_reg MSB and shift right (LSB first), bit_cnt++, baud_cnt=0.
  - After sample number Word_len: go to Parity, or to Stop if PARITY="none".
- Parity: at baud_cnt==Baud_div-1, sample rx_s. parity_err = sample XOR (^data) for "even"; sample XOR (~^data) for "odd".
- Stop: at baud_cnt==Baud_div-1, sample rx_s. Frame completes in that cycle:
  - rx_s==1: go to Idle immediately. This gives a half-bit early return so the next start edge is caught.
  - rx_s==0: frame_err=1; go to Break.
- Break: remain until rx_s==1, then go to Idle. A low line never produces repeated frames.
- Output buffer: one entry.
  - On frame completion with (!rx_data_valid | rx_data_ready), load rx_data and both flags, and set valid the next cycle.
  - If rx_data_valid & !rx_data_ready at completion: drop the new word, keep the old word, pulse rx_overrun for 1 cycle.
  - valid&ready with no new completion: clear valid next cycle.
  - Completion and a transfer in the same cycle: the new word replaces the old one, valid stays 1, no overrun.
- Latency: let t0 be the first edge with rx_s==0 in Idle. Start sample at t0+H. Data sample k (k=1..Word_len) at t0+H+k·Baud_div. Parity and stop samples follow at the same spacing. rx_data_valid rises 1 cycle after the stop sample.
- Widths: baud_cnt is $clog2(Baud_div) bits, bit_cnt is $clog2(Word_len+1) bits. No wrap beyond the compare values.
- rx_data_ready is ignored while valid=0 (no effect).

Decomposition:
- Package uart_pkg:
  - state encodings (shared with uart_tx)
  - function baud_div(clk_rate, Baud)
  - function parity_calc(data, PARITY), which uart_tx also uses
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1. It is instantiated once, on Uart_rx.

Test Plan (clk_rate=1600, Baud=100 → Baud_div=16, H=8; Word_len=8):
- PARITY="even", send 0xA5 with parity bit 0 and stop 1, ready held 1 → rx_data=0xA5, valid for 1 cycle at t0+8+10·16+1, parity_err=0, frame_err=0.
- Same frame but parity bit 1 → rx_data=0xA5, rx_parity_err=1. PARITY="odd" with 0x00 and parity bit 1 → parity_err=0.
- Stop bit driven 0, line held low for 40 cycles, then high, then a valid 0x3C frame:
  - first word: frame_err=1
  - no extra words while the line is low
  - then 0x3C with frame_err=0
- Low pulse of 5 cycles on idle line → no valid, state back to Idle. Next frame 0x5A is received correctly.
- Back-to-back 0x11, 0x22 with ready=0:
  - rx_data stays 0x11
  - rx_overrun pulses exactly 1 cycle at 0x22 completion
  - after ready=1, one transfer of 0x11 and valid drops
- rst asserted for 1 cycle mid-Data of 0x77, then a fresh frame 0xC3 → valid=0 through reset, no 0x77 output, 0xC3 received. PARITY="none" 0xFF frame (10 bits) → 0xFF, flags 0.
